// File: rtl/upg_pkg.sv
// rtl/upg_pkg.sv - shared state encoding and default header/address constants for the UART programmer
package upg_pkg;

   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE} upg_state_t;

   localparam int         ADDR_W_DEF   = 14;
   localparam logic [7:0] HDR_IMEM_DEF = 8'hA0;
   localparam logic [7:0] HDR_DMEM_DEF = 8'hA1;

endpackage

// File: rtl/upg_timeout_ctr.sv
// rtl/upg_timeout_ctr.sv - inter-byte idle counter; expired once TIMEOUT_CYC idle cycles have elapsed
module upg_timeout_ctr #(
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYC + 1);

   logic [W-1:0] cnt;

   // Saturates at the limit so a stalled abort cannot wrap back to a live count.
   always_ff @(posedge clk) begin
      if (!resetn || clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + W'(1);
      end
   end

   assign expired = (cnt == W'(TIMEOUT_CYC));

endmodule

// File: rtl/upg_loader.sv
// rtl/upg_loader.sv - UART byte stream to imem/dmem word writes; optional trailing XOR byte via UPG_CHECKSUM_EN
module upg_loader
   import upg_pkg::*;
#(
   parameter int         ADDR_W      = ADDR_W_DEF,
   parameter int         TIMEOUT_CYC = 1000000,
   parameter logic [7:0] HDR_IMEM    = HDR_IMEM_DEF,
   parameter logic [7:0] HDR_DMEM    = HDR_DMEM_DEF
) (
   input  logic              upg_clk_i,
   input  logic              upg_rstn_i,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   output logic              upg_wen_o,
   output logic [ADDR_W-1:0] upg_adr_o,
   output logic [31:0]       upg_dat_o,
   output logic              upg_sel_o,
   output logic              upg_busy_o,
   output logic              upg_done_o,
   output logic              upg_err_o
);

`ifdef UPG_CHECKSUM_EN
   localparam upg_state_t TAIL = CHK;
`else
   localparam upg_state_t TAIL = DONE;
`endif

   upg_state_t  state;
   logic [15:0] len;
   logic [15:0] len_next;
   logic [15:0] word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] dat_acc;
   logic        active;
   logic        expired;

   assign active   = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CHK);
   assign len_next = {rx_data_i, len[7:0]};

   upg_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk     (upg_clk_i),
      .resetn  (upg_rstn_i),
      .clr     (rx_valid_i || !active),
      .en      (active),
      .expired (expired)
   );

`ifdef UPG_CHECKSUM_EN
   logic [7:0] chk;

   always_ff @(posedge upg_clk_i) begin
      if (!upg_rstn_i || state == IDLE) begin
         chk <= '0;
      end else if (rx_valid_i && (state == LEN0 || state == LEN1 || state == DATA)) begin
         chk <= chk ^ rx_data_i;
      end
   end
`endif

   always_ff @(posedge upg_clk_i) begin
      if (!upg_rstn_i) begin
         state      <= IDLE;
         len        <= '0;
         word_idx   <= '0;
         byte_cnt   <= '0;
         dat_acc    <= '0;
         upg_wen_o  <= 1'b0;
         upg_adr_o  <= '0;
         upg_dat_o  <= '0;
         upg_sel_o  <= 1'b0;
         upg_busy_o <= 1'b0;
         upg_done_o <= 1'b0;
         upg_err_o  <= 1'b0;
      end else begin
         upg_wen_o <= 1'b0;
         // A byte arriving in the expiry cycle is processed; expiry only aborts on an idle cycle.
         if (active && !rx_valid_i && expired) begin
            upg_err_o  <= 1'b1;
            upg_busy_o <= 1'b0;
            state      <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (rx_valid_i && (rx_data_i == HDR_IMEM || rx_data_i == HDR_DMEM)) begin
                     upg_sel_o  <= (rx_data_i == HDR_DMEM);
                     upg_err_o  <= 1'b0;
                     upg_busy_o <= 1'b1;
                     word_idx   <= '0;
                     byte_cnt   <= '0;
                     state      <= LEN0;
                  end
               end
               LEN0: begin
                  if (rx_valid_i) begin
                     len[7:0] <= rx_data_i;
                     state    <= LEN1;
                  end
               end
               LEN1: begin
                  if (rx_valid_i) begin
                     len <= len_next;
                     if ({1'b0, len_next} > 17'(2 ** ADDR_W)) begin
                        upg_err_o  <= 1'b1;
                        upg_busy_o <= 1'b0;
                        state      <= IDLE;
                     end else if (len_next == 16'd0) begin
                        upg_busy_o <= (TAIL != DONE);
                        state      <= TAIL;
                     end else begin
                        state <= DATA;
                     end
                  end
               end
               DATA: begin
                  if (rx_valid_i) begin
                     byte_cnt <= byte_cnt + 2'd1;
                     case (byte_cnt)
                        2'd0: dat_acc[7:0]   <= rx_data_i;
                        2'd1: dat_acc[15:8]  <= rx_data_i;
                        2'd2: dat_acc[23:16] <= rx_data_i;
                        default: begin
                           upg_wen_o <= 1'b1;
                           upg_adr_o <= word_idx[ADDR_W-1:0];
                           upg_dat_o <= {rx_data_i, dat_acc};
                           word_idx  <= word_idx + 16'd1;
                           if (word_idx == len - 16'd1) begin
                              upg_busy_o <= (TAIL != DONE);
                              state      <= TAIL;
                           end
                        end
                     endcase
                  end
               end
`ifdef UPG_CHECKSUM_EN
               CHK: begin
                  if (rx_valid_i) begin
                     upg_busy_o <= 1'b0;
                     if (rx_data_i == chk) begin
                        state <= DONE;
                     end else begin
                        upg_err_o <= 1'b1;
                        state     <= IDLE;
                     end
                  end
               end
`endif
               DONE: begin
                  upg_busy_o <= 1'b0;
                  upg_done_o <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
